// File: rtl/task_join_pkg.sv
// Shared types for the task join barrier: barrier modes, FSM states and
// the mode normalisation used when a barrier is armed.
package task_join_pkg;

    localparam int N_LANES_DEF = 4;
    localparam int CNT_W_DEF   = 4;
    localparam int TS_W_DEF    = 16;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2,
        JOIN_RSVD = 2'd3
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } join_state_e;

    // The reserved encoding behaves as JOIN_ALL, so it is folded at arm time
    // and the FSM never has to consider it.
    function automatic join_mode_e norm_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return JOIN_ANY;
            2'd2:    return JOIN_NONE;
            default: return JOIN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/task_join_barrier_lane_tracker.sv
// Per-lane outstanding-job counter. Saturates at both ends and flags the
// offending pulse (done with nothing outstanding, spawn when full).
module lane_tracker #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spawn_i,
    input  logic done_i,
    output logic pending_o,
    output logic err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count: spawn and done together cancel, including at zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        unique case ({spawn_i, done_i})
            2'b10: begin
                if (cnt_q == {CNT_W{1'b1}}) err_d = 1'b1;
                else                        cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Counter and registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign pending_o = (cnt_q != '0);
    assign err_o     = err_q;

endmodule

// File: rtl/task_join_barrier.sv
// Completion side of a spawn-without-wait dispatcher: tracks outstanding
// jobs per lane and releases one armed barrier at a time.
//
//  state   | meaning
//  IDLE    | no barrier armed, arm_ready_o high
//  WAIT    | barrier armed, collecting done pulses on masked lanes
//  RELEASE | join_valid_o high, results frozen until join_ready_i
module task_join_barrier
    import task_join_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TS_W    = TS_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] spawn_i,
    input  logic [N_LANES-1:0] done_i,
    input  logic               arm_valid_i,
    output logic               arm_ready_o,
    input  logic [1:0]         arm_mode_i,
    input  logic [N_LANES-1:0] arm_mask_i,
    output logic               join_valid_o,
    input  logic               join_ready_i,
    output logic [N_LANES-1:0] join_mask_o,
    output logic [TS_W-1:0]    join_time_o,
    output logic [N_LANES-1:0] pending_o,
    output logic               err_unexp_o
);

    logic [N_LANES-1:0] lane_err;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_tracker #(.CNT_W(CNT_W)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .spawn_i   (spawn_i[g]),
            .done_i    (done_i[g]),
            .pending_o (pending_o[g]),
            .err_o     (lane_err[g])
        );
    end

    assign err_unexp_o = |lane_err;

    join_state_e        state_q, state_d;
    join_mode_e         mode_q, mode_d;
    logic [N_LANES-1:0] mask_q, mask_d;
    logic [N_LANES-1:0] seen_q, seen_d;
    logic [TS_W-1:0]    elapsed_q, elapsed_d;

    // An empty mask releases immediately whatever the mode.
    function automatic logic release_hit(input join_mode_e mode,
                                         input logic [N_LANES-1:0] seen,
                                         input logic [N_LANES-1:0] mask);
        if (mask == '0) return 1'b1;
        case (mode)
            JOIN_ANY:  return |(seen & mask);
            JOIN_NONE: return 1'b1;
            default:   return (seen & mask) == mask;
        endcase
    endfunction

    function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
        return (v == {TS_W{1'b1}}) ? v : v + TS_W'(1);
    endfunction

    // Next-state and outputs. The release test runs on the updated seen set,
    // including at arm accept, so a qualifying done releases one cycle later.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        mask_d       = mask_q;
        seen_d       = seen_q;
        elapsed_d    = elapsed_q;
        arm_ready_o  = 1'b0;
        join_valid_o = 1'b0;
        join_mask_o  = '0;
        join_time_o  = '0;
        unique case (state_q)
            IDLE: begin
                arm_ready_o = 1'b1;
                if (arm_valid_i) begin
                    mode_d    = norm_mode(arm_mode_i);
                    mask_d    = arm_mask_i;
                    elapsed_d = '0;
                    seen_d    = done_i & arm_mask_i;
                    state_d   = release_hit(norm_mode(arm_mode_i), seen_d, arm_mask_i)
                                ? RELEASE : WAIT;
                end
            end
            WAIT: begin
                elapsed_d = sat_inc(elapsed_q);
                seen_d    = seen_q | (done_i & mask_q);
                if (release_hit(mode_q, seen_d, mask_q)) state_d = RELEASE;
            end
            RELEASE: begin
                join_valid_o = 1'b1;
                join_mask_o  = seen_q;
                join_time_o  = sat_inc(elapsed_q);
                if (join_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Barrier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= JOIN_ALL;
            mask_q    <= '0;
            seen_q    <= '0;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            seen_q    <= seen_d;
            elapsed_q <= elapsed_d;
        end
    end

endmodule
